spi_reg_access: RTL

- Register-access controller that sequences the byte-stream SPI master core for register transfers.
- Accepts one read/write command (15-bit address, 8-bit data) and emits a fixed 3-byte frame on the master's TX byte stream, keeping TX valid continuous so slave select stays low for the whole frame.
- Counts the returned RX bytes and reports completion, read data or a timeout error.
- Sits between register-map clients (config FSMs, CPU bridge) and the SPI master.

---
 rtl/spi_reg_access_if.sv | 39 +++
 rtl/spi_reg_access.sv | 134 +++++++++++++
 2 files changed

// File: rtl/spi_reg_access_if.sv
// Bus bundle for the SPI register-access controller: command, response and
// byte-stream SPI master signals grouped in one interface.
//
// Handshake rules: a transfer on cmd_* or spi_tx_* happens on a rising clk
// edge where both valid and ready are 1. Once raised, valid stays high and
// its payload stays stable until that edge. rsp_valid and spi_rx_valid are
// one-cycle strobes with no backpressure.
interface spi_reg_access_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rw;
  logic [14:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic [7:0]  spi_tx_data;
  logic        spi_tx_valid;
  logic        spi_tx_ready;
  logic [7:0]  spi_rx_data;
  logic        spi_rx_valid;

  // Controller side
  modport slave (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
    input  spi_tx_ready, spi_rx_data, spi_rx_valid,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
    output spi_tx_data, spi_tx_valid
  );

  // Client / SPI-master side
  modport master (
    output cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
    output spi_tx_ready, spi_rx_data, spi_rx_valid,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
    input  spi_tx_data, spi_tx_valid
  );
endinterface

// File: rtl/spi_reg_access.sv
// Register-access controller: turns one read/write command into a 3-byte
// frame on the SPI master's TX byte stream, counts the returned RX bytes and
// reports completion, read data or a timeout. TIMEOUT_CYCLES must be >= 2.
module spi_reg_access #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             rst,
  spi_reg_access_if.slave  bus,
  output logic [1:0]       o_dbg_state
);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]    r_state;
  logic [7:0]    r_b0, r_b1, r_b2;
  logic          r_rw;
  logic [1:0]    r_tx_idx;
  logic [1:0]    r_rx_cnt;
  logic [TW-1:0] r_tmo;
  logic          r_cmd_ready;
  logic          r_rsp_valid;
  logic [7:0]    r_rsp_rdata;
  logic          r_rsp_err;
  logic          r_busy;
  logic          r_tx_valid;
  logic [7:0]    r_tx_data;

  logic [TW-1:0] w_tmo_next;
  logic          w_tmo_hit;
  logic          w_done;
  logic          w_tx_fire;
  logic [7:0]    w_next_byte;

  assign w_tmo_next  = r_tmo + 1'b1;
  assign w_tmo_hit   = (w_tmo_next == TW'(TIMEOUT_CYCLES));
  // Third RX byte of the frame completes the transfer.
  assign w_done      = bus.spi_rx_valid && (r_rx_cnt == 2'd2);
  assign w_tx_fire   = r_tx_valid && bus.spi_tx_ready;
  assign w_next_byte = (r_tx_idx == 2'd0) ? r_b1 : r_b2;

  // Transaction sequencer; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_b0        <= '0;
      r_b1        <= '0;
      r_b2        <= '0;
      r_rw        <= 1'b0;
      r_tx_idx    <= '0;
      r_rx_cnt    <= '0;
      r_tmo       <= '0;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b0;
      r_tx_valid  <= 1'b0;
      r_tx_data   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (bus.cmd_valid && r_cmd_ready) begin
            r_b0        <= {bus.cmd_rw, bus.cmd_addr[14:8]};
            r_b1        <= bus.cmd_addr[7:0];
            r_b2        <= bus.cmd_rw ? 8'h00 : bus.cmd_wdata;
            r_rw        <= bus.cmd_rw;
            r_tx_idx    <= '0;
            r_rx_cnt    <= '0;
            r_tmo       <= '0;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_tx_valid  <= 1'b1;
            r_tx_data   <= {bus.cmd_rw, bus.cmd_addr[14:8]};
            r_state     <= S_SEND;
          end
        end
        S_SEND, S_WAIT: begin
          r_tmo <= w_tmo_next;
          // RX bytes may overlap pending TX bytes, so they are counted separately.
          if (bus.spi_rx_valid) r_rx_cnt <= r_rx_cnt + 2'd1;
          if (w_done) begin
            r_tx_valid  <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= r_rw ? bus.spi_rx_data : 8'h00;
            r_rsp_err   <= 1'b0;
            r_state     <= S_RESP;
          end else if (w_tmo_hit) begin
            r_tx_valid  <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= 8'h00;
            r_rsp_err   <= 1'b1;
            r_state     <= S_RESP;
          end else if ((r_state == S_SEND) && w_tx_fire) begin
            if (r_tx_idx == 2'd2) begin
              r_tx_valid <= 1'b0;
              r_state    <= S_WAIT;
            end else begin
              r_tx_idx  <= r_tx_idx + 2'd1;
              r_tx_data <= w_next_byte;
            end
          end
        end
        S_RESP: begin
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_tx_valid  <= 1'b0;
          r_cmd_ready <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready    = r_cmd_ready;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_rdata    = r_rsp_rdata;
  assign bus.rsp_err      = r_rsp_err;
  assign bus.busy         = r_busy;
  assign bus.spi_tx_valid = r_tx_valid;
  assign bus.spi_tx_data  = r_tx_data;
  assign o_dbg_state      = r_state;
endmodule
